// File: rtl/frontend_cmd_issuer_if.sv
// Frontend <-> user/backend bus of frontend_cmd_issuer. Signal names are from the issuer's view.
// master: the issuer; slave: the user and backend driving it.
interface frontend_cmd_issuer_if #(
    parameter int unsigned ROW_BITS = 16,
    parameter int unsigned COL_BITS = 4,
    parameter int unsigned DATA_W   = 128
);
    logic                       i_req_valid;
    logic                       o_req_ready;
    logic                       i_req_write;
    logic [ROW_BITS-1:0]        i_req_row;
    logic [COL_BITS-1:0]        i_req_col;
    logic [DATA_W-1:0]          i_req_wdata;
    logic                       o_frontend_command_valid;
    logic                       i_backend_controller_ready;
    logic [ROW_BITS+COL_BITS:0] o_frontend_command;
    logic [DATA_W-1:0]          o_frontend_write_data;
    logic                       i_backend_controller_ren;
    logic [DATA_W-1:0]          i_backend_read_data;
    logic                       i_backend_read_data_valid;
    logic                       o_backend_controller_stall;
    logic                       o_frontend_controller_ready;
    logic                       o_rsp_valid;
    logic                       i_rsp_ready;
    logic [DATA_W-1:0]          o_rsp_rdata;
    logic [1:0]                 o_err;
    logic [31:0]                o_rd_cnt;
    logic [31:0]                o_wr_cnt;

    modport master (
        input  i_req_valid, i_req_write, i_req_row, i_req_col, i_req_wdata,
        input  i_backend_controller_ready, i_backend_controller_ren,
        input  i_backend_read_data, i_backend_read_data_valid, i_rsp_ready,
        output o_req_ready, o_frontend_command_valid, o_frontend_command,
        output o_frontend_write_data, o_backend_controller_stall,
        output o_frontend_controller_ready, o_rsp_valid, o_rsp_rdata,
        output o_err, o_rd_cnt, o_wr_cnt
    );

    modport slave (
        output i_req_valid, i_req_write, i_req_row, i_req_col, i_req_wdata,
        output i_backend_controller_ready, i_backend_controller_ren,
        output i_backend_read_data, i_backend_read_data_valid, i_rsp_ready,
        input  o_req_ready, o_frontend_command_valid, o_frontend_command,
        input  o_frontend_write_data, o_backend_controller_stall,
        input  o_frontend_controller_ready, o_rsp_valid, o_rsp_rdata,
        input  o_err, o_rd_cnt, o_wr_cnt
    );
endinterface

// File: rtl/frontend_cmd_issuer.sv
// Frontend command issuer: cmd/wdata FIFOs, credited read-return buffer, stall generation.
// Optional issue counters are built when FRONTEND_PERF_CNT_EN is defined.
module frontend_cmd_issuer #(
    parameter int unsigned ROW_BITS     = 16,
    parameter int unsigned COL_BITS     = 4,
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned CMD_DEPTH    = 8,
    parameter int unsigned WD_DEPTH     = 8,
    parameter int unsigned RD_DEPTH     = 8,
    parameter int unsigned STALL_MARGIN = 2
) (
    input logic                   clk,
    input logic                   power_on_rst_n,
    frontend_cmd_issuer_if.master bus
);
    localparam int unsigned CMD_W  = 1 + ROW_BITS + COL_BITS;
    localparam int unsigned CMD_AW = $clog2(CMD_DEPTH);
    localparam int unsigned WD_AW  = $clog2(WD_DEPTH);
    localparam int unsigned RD_AW  = $clog2(RD_DEPTH);
    localparam int unsigned CMD_PW = CMD_AW + 1;
    localparam int unsigned WD_PW  = WD_AW + 1;
    localparam int unsigned RC_W   = RD_AW + 1;
    localparam logic [RC_W-1:0] RD_LIMIT  = RC_W'(RD_DEPTH);
    localparam logic [RC_W-1:0] RD_MARGIN = RC_W'(STALL_MARGIN);

    logic [CMD_W-1:0]  r_cmd_mem [CMD_DEPTH];
    logic [DATA_W-1:0] r_wd_mem  [WD_DEPTH];
    logic [DATA_W-1:0] r_rd_mem  [RD_DEPTH];
    logic [CMD_PW-1:0] r_cmd_wptr, r_cmd_rptr;
    logic [WD_PW-1:0]  r_wd_wptr, r_wd_rptr;
    logic [RC_W-1:0]   r_rd_wptr, r_rd_rptr;
    logic [RC_W-1:0]   r_rd_credit;
    logic [1:0]        r_err;
    logic              r_stall, r_ctrl_ready, r_active;

    logic              w_cmd_empty, w_cmd_full, w_wd_empty, w_wd_full, w_rd_empty, w_rd_full;
    logic [CMD_W-1:0]  w_cmd_head;
    logic              w_head_write, w_cmd_valid, w_req_ready, w_req_fire, w_cmd_fire;
    logic              w_rd_issue, w_wr_issue, w_wd_push, w_wd_pop, w_wd_underrun;
    logic              w_rsp_pop, w_rd_push, w_rd_overflow;
    logic [RC_W-1:0]   w_rd_count, w_rd_count_next;

    // Full when the wrap bits differ and the index bits match.
    assign w_cmd_empty = (r_cmd_wptr == r_cmd_rptr);
    assign w_cmd_full  = (r_cmd_wptr[CMD_AW] != r_cmd_rptr[CMD_AW]) &&
                         (r_cmd_wptr[CMD_AW-1:0] == r_cmd_rptr[CMD_AW-1:0]);
    assign w_wd_empty  = (r_wd_wptr == r_wd_rptr);
    assign w_wd_full   = (r_wd_wptr[WD_AW] != r_wd_rptr[WD_AW]) &&
                         (r_wd_wptr[WD_AW-1:0] == r_wd_rptr[WD_AW-1:0]);
    assign w_rd_empty  = (r_rd_wptr == r_rd_rptr);
    assign w_rd_full   = (r_rd_wptr[RD_AW] != r_rd_rptr[RD_AW]) &&
                         (r_rd_wptr[RD_AW-1:0] == r_rd_rptr[RD_AW-1:0]);

    assign w_cmd_head   = r_cmd_mem[r_cmd_rptr[CMD_AW-1:0]];
    assign w_head_write = w_cmd_head[CMD_W-1];
    assign w_cmd_valid  = !w_cmd_empty && (w_head_write || (r_rd_credit < RD_LIMIT));
    assign w_req_ready  = r_active && !w_cmd_full && (!bus.i_req_write || !w_wd_full);
    assign w_req_fire   = bus.i_req_valid && w_req_ready;
    assign w_cmd_fire   = w_cmd_valid && bus.i_backend_controller_ready;
    assign w_rd_issue   = w_cmd_fire && !w_head_write;
    assign w_wr_issue   = w_cmd_fire && w_head_write;

    assign w_wd_push     = w_req_fire && bus.i_req_write;
    assign w_wd_pop      = bus.i_backend_controller_ren && !w_wd_empty;
    assign w_wd_underrun = bus.i_backend_controller_ren && w_wd_empty;

    // A same-cycle user pop frees a slot for the incoming burst.
    assign w_rsp_pop     = !w_rd_empty && bus.i_rsp_ready;
    assign w_rd_push     = bus.i_backend_read_data_valid && (!w_rd_full || w_rsp_pop);
    assign w_rd_overflow = bus.i_backend_read_data_valid && w_rd_full && !w_rsp_pop;

    assign w_rd_count      = r_rd_wptr - r_rd_rptr;
    assign w_rd_count_next = w_rd_count + RC_W'(w_rd_push) - RC_W'(w_rsp_pop);

    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_cmd_mem[r_cmd_wptr[CMD_AW-1:0]] <= {bus.i_req_write, bus.i_req_row, bus.i_req_col};
        end
        if (w_wd_push) r_wd_mem[r_wd_wptr[WD_AW-1:0]] <= bus.i_req_wdata;
        if (w_rd_push) r_rd_mem[r_rd_wptr[RD_AW-1:0]] <= bus.i_backend_read_data;
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            r_cmd_wptr   <= '0;
            r_cmd_rptr   <= '0;
            r_wd_wptr    <= '0;
            r_wd_rptr    <= '0;
            r_rd_wptr    <= '0;
            r_rd_rptr    <= '0;
            r_rd_credit  <= '0;
            r_err        <= '0;
            r_stall      <= 1'b0;
            r_ctrl_ready <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_req_fire) r_cmd_wptr <= r_cmd_wptr + CMD_PW'(1);
            if (w_cmd_fire) r_cmd_rptr <= r_cmd_rptr + CMD_PW'(1);
            if (w_wd_push)  r_wd_wptr  <= r_wd_wptr + WD_PW'(1);
            if (w_wd_pop)   r_wd_rptr  <= r_wd_rptr + WD_PW'(1);
            if (w_rd_push)  r_rd_wptr  <= r_rd_wptr + RC_W'(1);
            if (w_rsp_pop)  r_rd_rptr  <= r_rd_rptr + RC_W'(1);
            if (w_rd_issue && !w_rsp_pop) begin
                r_rd_credit <= r_rd_credit + RC_W'(1);
            end else if (!w_rd_issue && w_rsp_pop) begin
                r_rd_credit <= r_rd_credit - RC_W'(1);
            end
            r_err        <= r_err | {w_rd_overflow, w_wd_underrun};
            r_stall      <= (RD_LIMIT - w_rd_count_next) <= RD_MARGIN;
            r_ctrl_ready <= w_rd_count_next < RD_LIMIT;
        end
    end

    assign bus.o_req_ready                 = w_req_ready;
    assign bus.o_frontend_command_valid    = w_cmd_valid;
    assign bus.o_frontend_command          = w_cmd_empty ? '0 : w_cmd_head;
    assign bus.o_frontend_write_data       = w_wd_empty ? '0 : r_wd_mem[r_wd_rptr[WD_AW-1:0]];
    assign bus.o_backend_controller_stall  = r_stall;
    assign bus.o_frontend_controller_ready = r_ctrl_ready;
    assign bus.o_rsp_valid                 = !w_rd_empty;
    assign bus.o_rsp_rdata                 = w_rd_empty ? '0 : r_rd_mem[r_rd_rptr[RD_AW-1:0]];
    assign bus.o_err                       = r_err;

`ifdef FRONTEND_PERF_CNT_EN
    logic [31:0] r_rd_cnt, r_wr_cnt;

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_issue && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_wr_issue && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    assign bus.o_rd_cnt = r_rd_cnt;
    assign bus.o_wr_cnt = r_wr_cnt;
`else
    assign bus.o_rd_cnt = '0;
    assign bus.o_wr_cnt = '0;
`endif
endmodule

// File: tb/tb_frontend_cmd_issuer.sv
// Bench for frontend_cmd_issuer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_frontend_cmd_issuer;
    localparam int ROW_BITS = 16;
    localparam int COL_BITS = 4;
    localparam int DATA_W   = 128;
    localparam int DEPTH    = 8;
    localparam int MARGIN   = 2;
    localparam int CMD_W    = 1 + ROW_BITS + COL_BITS;

    logic clk = 1'b0;
    logic power_on_rst_n = 1'b1;
    always #5 clk = ~clk;

    frontend_cmd_issuer_if #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .DATA_W(DATA_W)) bus ();

    frontend_cmd_issuer #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .DATA_W(DATA_W), .CMD_DEPTH(DEPTH),
        .WD_DEPTH(DEPTH), .RD_DEPTH(DEPTH), .STALL_MARGIN(MARGIN)
    ) dut (
        .clk(clk),
        .power_on_rst_n(power_on_rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int obs_rd = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: what the issuer holds after the latest clock edge.
    logic [CMD_W-1:0]  m_cmdq[$];
    logic [DATA_W-1:0] m_wdq[$];
    logic [DATA_W-1:0] m_rdq[$];
    int                m_credit;
    logic [1:0]        m_err;
    logic              m_stall, m_cready, m_active;
    logic [31:0]       m_rdn, m_wrn;

    always @(negedge clk) begin : cmp
        logic e_req_ready, e_cmd_valid, e_rsp_valid, head_wr, cmd_fire, rsp_pop;
        logic [CMD_W-1:0] e_cmd;
        logic [DATA_W-1:0] e_wdata, e_rdata;
        logic [31:0] e_rdn, e_wrn;
        if (!power_on_rst_n) begin
            m_cmdq.delete(); m_wdq.delete(); m_rdq.delete();
            m_credit = 0; m_err = 2'b00; m_stall = 1'b0; m_cready = 1'b0; m_active = 1'b0;
            m_rdn = 32'd0; m_wrn = 32'd0;
        end
        head_wr     = (m_cmdq.size() > 0) ? m_cmdq[0][CMD_W-1] : 1'b0;
        e_cmd       = (m_cmdq.size() > 0) ? m_cmdq[0] : '0;
        e_wdata     = (m_wdq.size() > 0) ? m_wdq[0] : '0;
        e_rdata     = (m_rdq.size() > 0) ? m_rdq[0] : '0;
        e_rsp_valid = m_rdq.size() > 0;
        e_req_ready = m_active && (m_cmdq.size() < DEPTH) &&
                      (!bus.i_req_write || (m_wdq.size() < DEPTH));
        e_cmd_valid = (m_cmdq.size() > 0) && (head_wr || (m_credit < DEPTH));
`ifdef FRONTEND_PERF_CNT_EN
        e_rdn = m_rdn; e_wrn = m_wrn;
`else
        e_rdn = 32'd0; e_wrn = 32'd0;
`endif
        chk("req_ready", bus.o_req_ready, e_req_ready);
        chk("cmd_valid", bus.o_frontend_command_valid, e_cmd_valid);
        chk("command", bus.o_frontend_command, e_cmd);
        chk("write_data", bus.o_frontend_write_data, e_wdata);
        chk("rsp_valid", bus.o_rsp_valid, e_rsp_valid);
        chk("rsp_rdata", bus.o_rsp_rdata, e_rdata);
        chk("stall", bus.o_backend_controller_stall, m_stall);
        chk("ctrl_ready", bus.o_frontend_controller_ready, m_cready);
        chk("err", bus.o_err, m_err);
        chk("rd_cnt", bus.o_rd_cnt, e_rdn);
        chk("wr_cnt", bus.o_wr_cnt, e_wrn);
        if (bus.o_frontend_command_valid && bus.i_backend_controller_ready &&
            !bus.o_frontend_command[CMD_W-1]) obs_rd++;
        if (power_on_rst_n) begin
            cmd_fire = e_cmd_valid && bus.i_backend_controller_ready;
            rsp_pop  = e_rsp_valid && bus.i_rsp_ready;
            if (cmd_fire) begin
                if (head_wr) begin
                    if (m_wrn != 32'hFFFF_FFFF) m_wrn++;
                end else begin
                    if (m_rdn != 32'hFFFF_FFFF) m_rdn++;
                    m_credit++;
                end
                void'(m_cmdq.pop_front());
            end
            if (rsp_pop) begin
                void'(m_rdq.pop_front());
                m_credit--;
            end
            if (bus.i_backend_read_data_valid) begin
                if (m_rdq.size() < DEPTH) m_rdq.push_back(bus.i_backend_read_data);
                else m_err[1] = 1'b1;
            end
            if (bus.i_backend_controller_ren) begin
                if (m_wdq.size() > 0) void'(m_wdq.pop_front());
                else m_err[0] = 1'b1;
            end
            if (bus.i_req_valid && e_req_ready) begin
                m_cmdq.push_back({bus.i_req_write, bus.i_req_row, bus.i_req_col});
                if (bus.i_req_write) m_wdq.push_back(bus.i_req_wdata);
            end
            m_stall  = (DEPTH - m_rdq.size()) <= MARGIN;
            m_cready = m_rdq.size() < DEPTH;
            m_active = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0; bus.i_req_row = '0; bus.i_req_col = '0;
        bus.i_req_wdata = '0; bus.i_backend_controller_ready = 1'b0;
        bus.i_backend_controller_ren = 1'b0; bus.i_backend_read_data = '0;
        bus.i_backend_read_data_valid = 1'b0; bus.i_rsp_ready = 1'b0;
    endtask

    task automatic push_req(input logic wr, input int row, input logic [DATA_W-1:0] wd);
        bus.i_req_valid = 1'b1; bus.i_req_write = wr;
        bus.i_req_row = ROW_BITS'(row); bus.i_req_col = COL_BITS'(row);
        bus.i_req_wdata = wd;
        step(1);
        bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        clear_inputs();
        #1 power_on_rst_n = 1'b0;
        step(3);
        #2;
        chk("rst_req_ready", bus.o_req_ready, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_ctrl_ready", bus.o_frontend_controller_ready, 0);
        power_on_rst_n = 1'b1;
        step(1);
        #2 chk("req_ready_after_rst", bus.o_req_ready, 1);

        // Single write: command one cycle after acceptance, data popped by ren.
        bus.i_req_valid = 1'b1; bus.i_req_write = 1'b1; bus.i_req_row = 16'd5;
        bus.i_req_col = 4'd3; bus.i_req_wdata = {16{8'hA5}};
        step(1);
        bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0;
        #2;
        chk("wr_cmd_valid", bus.o_frontend_command_valid, 1);
        chk("wr_cmd", bus.o_frontend_command, {1'b1, 16'd5, 4'd3});
        bus.i_backend_controller_ready = 1'b1;
        step(1);
        bus.i_backend_controller_ready = 1'b0;
        #2 chk("wr_cmd_popped", bus.o_frontend_command_valid, 0);
        step(3);
        bus.i_backend_controller_ren = 1'b1;
        #2 chk("ren_wdata", bus.o_frontend_write_data, {16{8'hA5}});
        step(1);
        bus.i_backend_controller_ren = 1'b0;
        #2 chk("wdata_empty", bus.o_frontend_write_data, 0);

        // Nine reads, no returns: credit limit holds the ninth.
        base = obs_rd;
        bus.i_backend_controller_ready = 1'b1; bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) push_req(1'b0, i + 1, '0);
        step(4);
        #2;
        chk("rd_issued_limit", 128'(obs_rd - base), 8);
        chk("rd9_held", bus.o_frontend_command_valid, 0);
        bus.i_backend_read_data_valid = 1'b1; bus.i_backend_read_data = 128'h1111;
        step(1);
        bus.i_backend_read_data_valid = 1'b0;
        step(3);
        #2 chk("rd9_issued", 128'(obs_rd - base), 9);
        for (int i = 0; i < 8; i++) begin
            bus.i_backend_read_data_valid = 1'b1; bus.i_backend_read_data = 128'(i + 2);
            step(1);
        end
        bus.i_backend_read_data_valid = 1'b0; bus.i_backend_controller_ready = 1'b0;
        step(3);
        #2 chk("rd_drained", bus.o_rsp_valid, 0);

        // Stall / controller-ready thresholds with user not popping.
        bus.i_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_backend_read_data_valid = 1'b1; bus.i_backend_read_data = 128'(16 + i);
            step(1);
        end
        #2 chk("stall_after5", bus.o_backend_controller_stall, 0);
        bus.i_backend_read_data = 128'(21);
        step(1);
        bus.i_backend_read_data_valid = 1'b0;
        #2;
        chk("stall_after6", bus.o_backend_controller_stall, 1);
        chk("cready_after6", bus.o_frontend_controller_ready, 1);
        bus.i_backend_read_data_valid = 1'b1; bus.i_backend_read_data = 128'(22);
        step(1);
        bus.i_backend_read_data = 128'(23);
        step(1);
        bus.i_backend_read_data_valid = 1'b0;
        #2;
        chk("cready_full", bus.o_frontend_controller_ready, 0);
        chk("rsp_head_full", bus.o_rsp_rdata, 16);

        // Full buffer: a pop alongside the return avoids a drop; without it, overflow.
        bus.i_rsp_ready = 1'b1; bus.i_backend_read_data_valid = 1'b1;
        bus.i_backend_read_data = 128'(100);
        step(1);
        bus.i_rsp_ready = 1'b0; bus.i_backend_read_data = 128'(200);
        #2 chk("no_ovf_with_pop", bus.o_err, 2'b00);
        step(1);
        bus.i_backend_read_data_valid = 1'b0;
        #2;
        chk("ovf_err", bus.o_err, 2'b10);
        chk("ovf_head_kept", bus.o_rsp_rdata, 17);

        // Underrun, then reset in the middle of traffic.
        power_on_rst_n = 1'b0;
        step(2);
        power_on_rst_n = 1'b1;
        step(1);
        bus.i_backend_controller_ren = 1'b1;
        step(1);
        bus.i_backend_controller_ren = 1'b0;
        #2 chk("underrun_err", bus.o_err, 2'b01);
        bus.i_backend_controller_ready = 1'b1;
        push_req(1'b1, 7, {16{8'hB6}});
        bus.i_backend_read_data_valid = 1'b1; bus.i_backend_read_data = 128'h55;
        push_req(1'b0, 9, '0);
        bus.i_req_valid = 1'b1; bus.i_req_write = 1'b1; bus.i_req_wdata = {16{8'hC7}};
        step(1);
        power_on_rst_n = 1'b0;
        #2;
        chk("mid_rst_cmd_valid", bus.o_frontend_command_valid, 0);
        chk("mid_rst_command", bus.o_frontend_command, 0);
        chk("mid_rst_wdata", bus.o_frontend_write_data, 0);
        chk("mid_rst_rsp_valid", bus.o_rsp_valid, 0);
        chk("mid_rst_err", bus.o_err, 0);
        chk("mid_rst_req_ready", bus.o_req_ready, 0);
        clear_inputs();
        step(2);
        power_on_rst_n = 1'b1;
        step(1);

        // Issue counters: 3 writes + 2 reads.
        bus.i_backend_controller_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_req(1'b1, i, 128'(i + 40));
        for (int i = 0; i < 2; i++) push_req(1'b0, i, '0);
        step(4);
        #2;
`ifdef FRONTEND_PERF_CNT_EN
        chk("wr_cnt_final", bus.o_wr_cnt, 3);
        chk("rd_cnt_final", bus.o_rd_cnt, 2);
`else
        chk("wr_cnt_final", bus.o_wr_cnt, 0);
        chk("rd_cnt_final", bus.o_rd_cnt, 0);
`endif
        clear_inputs();
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
